// File: rtl/seg_show_sched.sv
// Display-time scheduler for the 6-digit seven-segment display: round-robin over three
// status sources with a blank gap between owners, preempted by a latched alarm code.
module seg_show_sched #(
    parameter int unsigned DWELL      = 2000,
    parameter int unsigned GAP        = 100,
    parameter int unsigned ALARM_HOLD = 3000
) (
    input  logic        clk_1k,
    input  logic        rst,
    input  logic [23:0] src0_data,
    input  logic        src0_valid,
    input  logic [23:0] src1_data,
    input  logic        src1_valid,
    input  logic [23:0] src2_data,
    input  logic        src2_valid,
    input  logic        alarm_req,
    input  logic [23:0] alarm_code,
    output logic        alarm_ack,
    output logic [23:0] show_data,
    output logic        show_en,
    output logic [1:0]  show_src
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(ALARM_HOLD - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] show_data_q, show_data_d;
    logic        show_en_q, show_en_d;
    logic [1:0]  show_src_q, show_src_d;
    logic        ack_q, ack_d;

    logic [2:0] valid;
    logic [2:0] search_fwd;
    logic [2:0] search_inc;
    logic [2:0] search_low;
    logic       accept;

    assign valid = {src2_valid, src1_valid, src0_valid};

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Returns {found, index} of the first valid source at start, start+1, start+2 (mod 3).
    function automatic logic [2:0] find_valid(input logic [1:0] start, input logic [2:0] v);
        logic [1:0] p;
        logic [2:0] r;
        p = start;
        r = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (!r[2] && v[p]) begin
                r = {1'b1, p};
            end
            p = inc3(p);
        end
        return r;
    endfunction

    function automatic logic [23:0] data_of(input logic [1:0] idx, input logic [23:0] d0,
                                            input logic [23:0] d1, input logic [23:0] d2);
        case (idx)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    assign search_fwd = find_valid(inc3(ptr_q), valid);
    assign search_inc = find_valid(ptr_q, valid);
    assign search_low = find_valid(2'd0, valid);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        show_data_d = show_data_q;
        show_en_d   = show_en_q;
        show_src_d  = show_src_q;
        ack_d       = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (alarm_req) begin
                    accept = 1'b1;
                end else if (search_low[2]) begin
                    ptr_d   = search_low[1:0];
                    cnt_d   = 16'd0;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (alarm_req) begin
                    accept = 1'b1;
                end else if (!valid[ptr_q] || cnt_q == DWELL_LAST) begin
                    cnt_d = 16'd0;
                    if (!search_fwd[2]) begin
                        state_d = ST_IDLE;
                    end else if (search_fwd[1:0] != ptr_q) begin
                        ptr_d   = search_fwd[1:0];
                        state_d = ST_GAP;
                    end
                    // Sole valid source found again: stay in SHOW with a fresh dwell.
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (alarm_req) begin
                    accept = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = 16'd0;
                    if (search_inc[2]) begin
                        ptr_d   = search_inc[1:0];
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (cnt_q == HOLD_LAST) begin
                    if (alarm_req) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase

        // The interrupted source's pointer is deliberately left untouched.
        if (accept) begin
            state_d     = ST_ALARM;
            cnt_d       = 16'd0;
            show_data_d = alarm_code;
            ack_d       = 1'b1;
        end

        case (state_d)
            ST_SHOW: begin
                show_data_d = data_of(ptr_d, src0_data, src1_data, src2_data);
                show_en_d   = 1'b1;
                show_src_d  = ptr_d;
            end
            ST_ALARM: begin
                show_en_d  = 1'b1;
                show_src_d = 2'd3;
            end
            default: begin
                show_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1k) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= 16'd0;
            show_data_q <= 24'h000000;
            show_en_q   <= 1'b0;
            show_src_q  <= 2'd0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            show_data_q <= show_data_d;
            show_en_q   <= show_en_d;
            show_src_q  <= show_src_d;
            ack_q       <= ack_d;
        end
    end

    assign alarm_ack = ack_q;
    assign show_data = show_data_q;
    assign show_en   = show_en_q;
    assign show_src  = show_src_q;

endmodule

// File: tb/tb_seg_show_sched.sv
// Bench for seg_show_sched with shortened timing: a segment table drives inputs and queues
// per-cycle expectations, which are popped and compared after each clock edge.
module tb_seg_show_sched;

    localparam int unsigned DW = 8;
    localparam int unsigned GP = 3;
    localparam int unsigned AH = 10;

    localparam logic [23:0] D0  = 24'h123456;
    localparam logic [23:0] D1  = 24'hB1B1B1;
    localparam logic [23:0] D2  = 24'h00ABCD;
    localparam logic [23:0] A42 = 24'hE00042;
    localparam logic [23:0] A43 = 24'hE00043;

    logic        clk_1k = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] src0_data = D0, src1_data = D1, src2_data = D2;
    logic        src0_valid = 1'b0, src1_valid = 1'b0, src2_valid = 1'b0;
    logic        alarm_req = 1'b0;
    logic [23:0] alarm_code = 24'h0;
    logic        alarm_ack;
    logic [23:0] show_data;
    logic        show_en;
    logic [1:0]  show_src;

    always #5 clk_1k = ~clk_1k;

    seg_show_sched #(.DWELL(DW), .GAP(GP), .ALARM_HOLD(AH)) dut (
        .clk_1k     (clk_1k),
        .rst        (rst),
        .src0_data  (src0_data),
        .src0_valid (src0_valid),
        .src1_data  (src1_data),
        .src1_valid (src1_valid),
        .src2_data  (src2_data),
        .src2_valid (src2_valid),
        .alarm_req  (alarm_req),
        .alarm_code (alarm_code),
        .alarm_ack  (alarm_ack),
        .show_data  (show_data),
        .show_en    (show_en),
        .show_src   (show_src)
    );

    typedef struct {
        logic        en;
        logic [1:0]  src;
        logic [23:0] data;
        logic        ack;
        string       tag;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic        areq;
        logic [23:0] code;
        int          n;
        logic        en;
        logic [1:0]  src;
        logic [23:0] data;
        logic        ack;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic a,
                                input logic [23:0] c, input int n, input logic en,
                                input logic [1:0] src, input logic [23:0] d, input logic ack);
        vec_t x;
        x.rst = r; x.valid = v; x.areq = a; x.code = c; x.n = n;
        x.en = en; x.src = src; x.data = d; x.ack = ack;
        return x;
    endfunction

    task automatic check(input string tag, input logic [23:0] act, input logic [23:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, req);
        end
    endtask

    // Queue the expectation for the coming edge, then compare once the DUT has registered it.
    task automatic cycle(input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk_1k);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", e.tag);
        end else begin
            got = sb.pop_front();
            check($sformatf("%s.en", got.tag), 24'(show_en), 24'(got.en));
            check($sformatf("%s.src", got.tag), 24'(show_src), 24'(got.src));
            check($sformatf("%s.data", got.tag), show_data, got.data);
            check($sformatf("%s.ack", got.tag), 24'(alarm_ack), 24'(got.ack));
        end
    endtask

    initial begin
        exp_t e;
        logic [23:0] d;

        // Idle after reset
        tbl.push_back(mk(1, 3'b000, 0, 24'h0, 2,  0, 0, 24'h0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 24'h0, 50, 0, 0, 24'h0, 0));
        // src0/src2 rotation with wrap, src1 never shown
        tbl.push_back(mk(1, 3'b101, 0, 24'h0, 2,  0, 0, 24'h0, 0));
        tbl.push_back(mk(0, 3'b101, 0, 24'h0, DW, 1, 0, D0, 0));
        tbl.push_back(mk(0, 3'b101, 0, 24'h0, GP, 0, 0, D0, 0));
        tbl.push_back(mk(0, 3'b101, 0, 24'h0, DW, 1, 2, D2, 0));
        tbl.push_back(mk(0, 3'b101, 0, 24'h0, GP, 0, 2, D2, 0));
        tbl.push_back(mk(0, 3'b101, 0, 24'h0, 4,  1, 0, D0, 0));
        // Mid-operation reset with alarm pending: no ack while in reset
        tbl.push_back(mk(1, 3'b101, 1, A42,   2,  0, 0, 24'h0, 0));
        // src0 drops valid mid-dwell
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, 5,  1, 0, D0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 24'h0, 1,  0, 0, D0, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, GP - 1, 0, 0, D0, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, DW, 1, 1, D1, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, GP, 0, 1, D1, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, 1,  1, 0, D0, 0));
        // Alarm pulse during src1 dwell; code changes during hold are ignored
        tbl.push_back(mk(1, 3'b110, 0, 24'h0, 2,  0, 0, 24'h0, 0));
        tbl.push_back(mk(0, 3'b110, 0, 24'h0, 3,  1, 1, D1, 0));
        tbl.push_back(mk(0, 3'b110, 1, A42,   1,  1, 3, A42, 1));
        tbl.push_back(mk(0, 3'b110, 0, A43,   AH - 1, 1, 3, A42, 0));
        tbl.push_back(mk(0, 3'b110, 0, A43,   GP, 0, 3, A42, 0));
        tbl.push_back(mk(0, 3'b110, 0, 24'h0, DW, 1, 1, D1, 0));
        tbl.push_back(mk(0, 3'b110, 0, 24'h0, GP, 0, 1, D1, 0));
        tbl.push_back(mk(0, 3'b110, 0, 24'h0, 1,  1, 2, D2, 0));
        // Alarm held high through reset and across the hold boundary
        tbl.push_back(mk(1, 3'b000, 1, A42,   2,  0, 0, 24'h0, 0));
        tbl.push_back(mk(0, 3'b000, 1, A42,   1,  1, 3, A42, 1));
        tbl.push_back(mk(0, 3'b000, 1, A42,   4,  1, 3, A42, 0));
        tbl.push_back(mk(0, 3'b000, 1, A43,   AH - 5, 1, 3, A42, 0));
        tbl.push_back(mk(0, 3'b000, 1, A43,   1,  1, 3, A43, 1));
        tbl.push_back(mk(0, 3'b000, 0, A43,   AH - 1, 1, 3, A43, 0));
        tbl.push_back(mk(0, 3'b000, 0, A43,   GP + 2, 0, 3, A43, 0));
        // Alarm coincides with dwell expiry: alarm wins, src0 then gets a full dwell
        tbl.push_back(mk(1, 3'b011, 0, 24'h0, 2,  0, 0, 24'h0, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, DW, 1, 0, D0, 0));
        tbl.push_back(mk(0, 3'b011, 1, A42,   1,  1, 3, A42, 1));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, AH - 1, 1, 3, A42, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, GP, 0, 3, A42, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, DW, 1, 0, D0, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, GP, 0, 0, D0, 0));
        tbl.push_back(mk(0, 3'b011, 0, 24'h0, 1,  1, 1, D1, 0));

        for (int s = 0; s < tbl.size(); s++) begin
            rst        = tbl[s].rst;
            src0_valid = tbl[s].valid[0];
            src1_valid = tbl[s].valid[1];
            src2_valid = tbl[s].valid[2];
            alarm_req  = tbl[s].areq;
            alarm_code = tbl[s].code;
            for (int i = 0; i < tbl[s].n; i++) begin
                e.en   = tbl[s].en;
                e.src  = tbl[s].src;
                e.data = tbl[s].data;
                e.ack  = tbl[s].ack && (i == 0);
                e.tag  = $sformatf("seg%0d.c%0d", s, i);
                cycle(e);
            end
        end

        // Single source with live data: no gap at dwell boundaries, one-cycle lag
        rst = 1'b1;
        src0_valid = 1'b0; src1_valid = 1'b0; src2_valid = 1'b0;
        alarm_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e.en = 1'b0; e.src = 2'd0; e.data = 24'h0; e.ack = 1'b0;
            e.tag = $sformatf("live.rst%0d", i);
            cycle(e);
        end
        rst = 1'b0;
        src1_valid = 1'b1;
        d = 24'h000100;
        for (int i = 0; i < 3 * DW + 3; i++) begin
            src1_data = d;
            e.en = 1'b1; e.src = 2'd1; e.data = d; e.ack = 1'b0;
            e.tag = $sformatf("live.c%0d", i);
            cycle(e);
            d = d + 24'd1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
